// File: rtl/minesweeper_pkg.sv
// Shared constants, state encoding and board-index helper for the minesweeper
// board setup logic.
package minesweeper_pkg;

  localparam int CELL_W_DEF = 5;
  localparam logic [CELL_W_DEF-1:0] MINE_BIT = CELL_W_DEF'(1 << (CELL_W_DEF - 1));
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED0 = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GEN,
    CHECK,
    INC,
    DONE
  } state_e;

  // Row-major linear index of cell (x,y) on a board w cells wide.
  function automatic int cell_idx(input int x, input int y, input int w);
    return y * w + x;
  endfunction

endpackage

// File: rtl/mine_lfsr.sv
// 16-bit right-shifting Galois LFSR used to pick candidate mine cells.
// load has priority over step; next_o is the value one step ahead.
module mine_lfsr #(
  parameter logic [15:0] RESET_VAL = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        step_i,
  output logic [15:0] state_o,
  output logic [15:0] next_o
);
  import minesweeper_pkg::*;

  logic [15:0] lfsr_q, lfsr_d;

  assign next_o  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  assign state_o = lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = load_val_i;
    end else if (step_i) begin
      lfsr_d = next_o;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= RESET_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/mine_placer_ctrl.sv
// Board initialisation sequencer: clears every cell, drops numMines mines at
// LFSR-chosen cells (optionally sparing one) and bumps each mine's neighbours.
module mine_placer_ctrl #(
  parameter int          W      = 8,
  parameter int          H      = 8,
  parameter int          CELL_W = 5,
  parameter logic [15:0] SEED0  = minesweeper_pkg::SEED0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            seed,
  input  logic [$clog2(W*H):0]   numMines,
  input  logic                   safeEn,
  input  logic [$clog2(W)-1:0]   safeX,
  input  logic [$clog2(H)-1:0]   safeY,
  output logic [$clog2(W)-1:0]   bReadX,
  output logic [$clog2(H)-1:0]   bReadY,
  input  logic [CELL_W-1:0]      bReadValue,
  output logic                   bWriteEn,
  output logic [$clog2(W)-1:0]   bWriteX,
  output logic [$clog2(H)-1:0]   bWriteY,
  output logic [CELL_W-1:0]      bWriteValue,
  output logic                   bIncAdjacent,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);
  import minesweeper_pkg::*;

  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int SW = XW + YW;
  localparam int NW = $clog2(W * H) + 1;
  localparam logic [SW-1:0]     SCAN_LAST = '1;
  localparam logic [NW:0]       CELLS     = (NW + 1)'(W * H);
  localparam logic [CELL_W-1:0] MINE_MASK = {1'b1, {(CELL_W - 1){1'b0}}};

  state_e          state_q, state_d;
  logic [SW-1:0]   scan_q, scan_d;
  logic [NW-1:0]   placed_q, placed_d;
  logic [NW-1:0]   num_q, num_d;
  logic            safe_en_q, safe_en_d;
  logic [XW-1:0]   safe_x_q, safe_x_d;
  logic [YW-1:0]   safe_y_q, safe_y_d;
  logic [XW-1:0]   cx_q, cx_d;
  logic [YW-1:0]   cy_q, cy_d;
  logic [XW-1:0]   wx_q, rx_q;
  logic [YW-1:0]   wy_q, ry_q;
  logic            err_q, err_d;

  logic            lfsr_load, lfsr_step;
  logic [15:0]     lfsr_seed, lfsr_next;
  logic [15:0]     lfsr_state_unused;
  logic [15-SW:0]  lfsr_hi_unused;
  logic [NW:0]     limit;
  logic            too_many;
  logic            reject_cell;

  mine_lfsr #(
    .RESET_VAL(SEED0)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .load_i    (lfsr_load),
    .load_val_i(lfsr_seed),
    .step_i    (lfsr_step),
    .state_o   (lfsr_state_unused),
    .next_o    (lfsr_next)
  );

  assign lfsr_hi_unused = lfsr_next[15:SW];
  assign lfsr_seed      = (seed == 16'h0000) ? SEED0 : seed;
  assign limit          = CELLS - {{NW{1'b0}}, safeEn};
  assign too_many       = {1'b0, numMines} > limit;
  assign reject_cell    = bReadValue[CELL_W-1] ||
                          (safe_en_q && (cx_q == safe_x_q) && (cy_q == safe_y_q));
  assign busy           = (state_q != IDLE);
  assign error          = err_q;

  always_comb begin
    state_d      = state_q;
    scan_d       = scan_q;
    placed_d     = placed_q;
    num_d        = num_q;
    safe_en_d    = safe_en_q;
    safe_x_d     = safe_x_q;
    safe_y_d     = safe_y_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    err_d        = 1'b0;
    lfsr_load    = 1'b0;
    lfsr_step    = 1'b0;
    bReadX       = rx_q;
    bReadY       = ry_q;
    bWriteEn     = 1'b0;
    bWriteX      = wx_q;
    bWriteY      = wy_q;
    bWriteValue  = '0;
    bIncAdjacent = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (too_many) begin
            err_d = 1'b1;
          end else begin
            num_d     = numMines;
            safe_en_d = safeEn;
            safe_x_d  = safeX;
            safe_y_d  = safeY;
            scan_d    = '0;
            placed_d  = '0;
            lfsr_load = 1'b1;
            state_d   = CLEAR;
          end
        end
      end
      CLEAR: begin
        bWriteEn = 1'b1;
        bWriteX  = scan_q[XW-1:0];
        bWriteY  = scan_q[SW-1:XW];
        scan_d   = scan_q + 1'b1;
        if (scan_q == SCAN_LAST) begin
          state_d = (num_q == '0) ? DONE : GEN;
        end
      end
      GEN: begin
        lfsr_step = 1'b1;
        cx_d      = lfsr_next[XW-1:0];
        cy_d      = lfsr_next[SW-1:XW];
        state_d   = CHECK;
      end
      CHECK: begin
        bReadX = cx_q;
        bReadY = cy_q;
        if (reject_cell) begin
          state_d = GEN;
        end else begin
          // Keep the neighbour count already accumulated in this cell.
          bWriteEn    = 1'b1;
          bWriteX     = cx_q;
          bWriteY     = cy_q;
          bWriteValue = bReadValue | MINE_MASK;
          state_d     = INC;
        end
      end
      INC: begin
        bIncAdjacent = 1'b1;
        bWriteX      = cx_q;
        bWriteY      = cy_q;
        placed_d     = placed_q + 1'b1;
        state_d      = (placed_d == num_q) ? DONE : GEN;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address outputs hold their last driven value outside the access states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      scan_q    <= '0;
      placed_q  <= '0;
      num_q     <= '0;
      safe_en_q <= 1'b0;
      safe_x_q  <= '0;
      safe_y_q  <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      wx_q      <= '0;
      wy_q      <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      scan_q    <= scan_d;
      placed_q  <= placed_d;
      num_q     <= num_d;
      safe_en_q <= safe_en_d;
      safe_x_q  <= safe_x_d;
      safe_y_q  <= safe_y_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      wx_q      <= bWriteX;
      wy_q      <= bWriteY;
      rx_q      <= bReadX;
      ry_q      <= bReadY;
      err_q     <= err_d;
    end
  end

endmodule
